// File: rtl/reg_pipeline.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse,
// back-pressure, synchronous flush and a registered occupancy count.
module reg_pipeline #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] acc;
    logic [WIDTH-1:0] data [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // A stage can take a word if it is empty or its occupant moves on this cycle.
    always_comb begin
        acc = '0;
        acc[DEPTH-1] = !valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            acc[i] = !valid[i] | acc[i+1];
        end
    end

    assign in_ready  = acc[0] & !flush & rst_n;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign out_fire  = valid[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            valid <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VALUE;
            end
        end else begin
            if (acc[0]) begin
                valid[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= in_data;
                end
            end
            // Data registers only move when a valid word enters; empty stages keep stale data.
            for (int i = 1; i < DEPTH; i++) begin
                if (acc[i]) begin
                    valid[i] <= valid[i-1];
                    if (valid[i-1]) begin
                        data[i] <= data[i-1];
                    end
                end
            end
            if (in_fire && !out_fire) begin
                count <= count + CW'(1);
            end else if (!in_fire && out_fire) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_pipeline.sv
// Self-checking bench for reg_pipeline: vector table, directed corner cases and
// randomized traffic against a word/position queue model.
module tb_reg_pipeline;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] count;

    logic       d1_flush = 1'b0;
    logic       d1_in_valid = 1'b0;
    logic [7:0] d1_in_data = '0;
    logic       d1_out_ready = 1'b0;
    logic       d1_in_ready;
    logic       d1_out_valid;
    logic [7:0] d1_out_data;
    logic [0:0] d1_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq_data [$];
    int         mq_pos  [$];

    typedef struct {
        logic       inv;
        logic [7:0] d;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [9];

    reg_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    reg_pipeline #(.WIDTH(W), .DEPTH(1), .RESET_VALUE(RV)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
        .count(d1_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of accepted words, each tagged with its stage position.
    function automatic bit m_in_ready(input logic ordy, input logic fl);
        return !fl && (mq_data.size() < D || ordy);
    endfunction

    function automatic bit m_out_valid();
        return mq_data.size() > 0 && mq_pos[0] == D - 1;
    endfunction

    task automatic m_update(input logic inv, input logic [7:0] d, input logic ordy, input logic fl);
        bit ir;
        bit ov;
        ir = m_in_ready(ordy, fl);
        ov = m_out_valid();
        if (fl) begin
            mq_data.delete();
            mq_pos.delete();
            return;
        end
        if (ov && ordy) begin
            void'(mq_data.pop_front());
            void'(mq_pos.pop_front());
        end
        for (int i = 0; i < mq_pos.size(); i++) begin
            int lim;
            lim = (i == 0) ? D - 1 : mq_pos[i-1] - 1;
            mq_pos[i] = (mq_pos[i] + 1 < lim) ? mq_pos[i] + 1 : lim;
        end
        if (inv && ir) begin
            mq_data.push_back(d);
            mq_pos.push_back(0);
        end
    endtask

    task automatic drive(input logic inv, input logic [7:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = inv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic applyStimulus(input logic inv, input logic [7:0] d, input logic ordy, input logic fl);
        drive(inv, d, ordy, fl);
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(m_in_ready(ordy, fl)));
        checkOutput("out_valid", 32'(out_valid), 32'(m_out_valid()));
        checkOutput("count", 32'(count), 32'(mq_data.size()));
        if (m_out_valid()) checkOutput("out_data", 32'(out_data), 32'(mq_data[0]));
        @(posedge clk);
        m_update(inv, d, ordy, fl);
    endtask

    initial begin
        int edges;

        vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[3] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1, 2};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1, 2};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 2};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB2, 1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_count", 32'(count), 32'(0));
        checkOutput("rst_out_data", 32'(out_data), 32'(RV));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bubble collapse from the vector table.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].inv, vecs[i].d, vecs[i].ordy, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_ov) checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            @(posedge clk);
            m_update(vecs[i].inv, vecs[i].d, vecs[i].ordy, 1'b0);
        end

        // DEPTH=1: simultaneous fire when full, one word per cycle.
        @(negedge clk);
        d1_in_valid  = 1'b1;
        d1_in_data   = 8'h50;
        d1_out_ready = 1'b1;
        #1;
        checkOutput("d1_empty_in_ready", 32'(d1_in_ready), 32'(1));
        checkOutput("d1_empty_out_valid", 32'(d1_out_valid), 32'(0));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            d1_in_data = 8'(8'h50 + k);
            #1;
            checkOutput("d1_out_valid", 32'(d1_out_valid), 32'(1));
            checkOutput("d1_out_data", 32'(d1_out_data), 32'(8'h50 + k - 1));
            checkOutput("d1_count", 32'(d1_count), 32'(1));
            checkOutput("d1_full_in_ready", 32'(d1_in_ready), 32'(1));
        end
        @(negedge clk);
        d1_out_ready = 1'b0;
        d1_in_data   = 8'h60;
        #1;
        checkOutput("d1_stall_in_ready", 32'(d1_in_ready), 32'(0));
        checkOutput("d1_stall_out_data", 32'(d1_out_data), 32'(8'h58));
        @(negedge clk);
        #1;
        checkOutput("d1_hold_out_data", 32'(d1_out_data), 32'(8'h58));
        checkOutput("d1_hold_count", 32'(d1_count), 32'(1));
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("d1_drain_out_valid", 32'(d1_out_valid), 32'(0));
        checkOutput("d1_drain_count", 32'(d1_count), 32'(0));
        d1_out_ready = 1'b0;

        // Streaming back-to-back.
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b1, 1'b0);
            if (k == 20) begin
                #1;
                checkOutput("stream_count_steady", 32'(count), 32'(4));
            end
        end
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-pressure.
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
        #1;
        checkOutput("bp_count", 32'(count), 32'(4));
        checkOutput("bp_in_ready", 32'(in_ready), 32'(0));
        checkOutput("bp_out_data", 32'(out_data), 32'(8'h60));
        applyStimulus(1'b1, 8'h64, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h65, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("bp_drained_count", 32'(count), 32'(0));

        // Flush with a word offered in the flush cycle.
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC4, 1'b0, 1'b1);
        #1;
        checkOutput("flush_count", 32'(count), 32'(0));
        checkOutput("flush_out_valid", 32'(out_valid), 32'(0));
        checkOutput("flush_out_data", 32'(out_data), 32'(RV));
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic, alternating light and heavy back-pressure.
        for (int n = 0; n < 400; n++) begin
            logic inv;
            logic ordy;
            logic fl;
            inv  = ($urandom_range(0, 3) != 0);
            ordy = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 49) == 0);
            applyStimulus(inv, 8'($urandom), ordy, fl);
        end

        // Reset asserted mid-transfer, between clock edges.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'(8'h70 + k), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'(0));
        checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("midrst_count", 32'(count), 32'(0));
        checkOutput("midrst_out_data", 32'(out_data), 32'(RV));
        mq_data.delete();
        mq_pos.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        checkOutput("first_accept_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        m_update(1'b1, 8'h11, 1'b1, 1'b0);
        edges = 1;
        while (edges < 10) begin
            #1;
            if (out_valid) break;
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            edges++;
        end
        checkOutput("latency_edges", 32'(edges), 32'(4));
        checkOutput("latency_out_data", 32'(out_data), 32'(8'h11));
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
